// File: rtl/overlap_tile_transposer_if.sv
// Column-in / row-out stream bundle for overlap_tile_transposer.
// The slave modport is the transposer's view; the master modport is its surroundings.
interface overlap_tile_transposer_if #(
    parameter int N         = 6,
    parameter int PIX_WIDTH = 8,
    parameter int OUT_WIDTH = 8
);
    logic                   en_i;
    logic                   valid_i;
    logic [PIX_WIDTH*N-1:0] column_i;
    logic                   ready_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [OUT_WIDTH*N-1:0] row_o;
    logic                   last_o;

    modport master (
        output en_i, valid_i, column_i, ready_i,
        input  ready_o, valid_o, row_o, last_o
    );

    modport slave (
        input  en_i, valid_i, column_i, ready_i,
        output ready_o, valid_o, row_o, last_o
    );
endinterface

// File: rtl/overlap_tile_transposer.sv
// Gathers N overlapped columns into a ping-pong N x N tile and re-emits it row by row.
// Define OVERLAP_TILE_SATURATE_EN to clamp pixels on narrowing instead of truncating.
module overlap_tile_transposer #(
    parameter int N         = 6,
    parameter int PIX_WIDTH = 8,
    parameter int OUT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    overlap_tile_transposer_if.slave  bus
);
    localparam int             CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);

    if (OUT_WIDTH > PIX_WIDTH) begin : g_width_check
        $error("overlap_tile_transposer: OUT_WIDTH must not exceed PIX_WIDTH");
    end

    function automatic logic [OUT_WIDTH-1:0] narrow(input logic [PIX_WIDTH-1:0] x);
`ifdef OVERLAP_TILE_SATURATE_EN
        if ((x >> OUT_WIDTH) != '0) begin
            return '1;
        end
        return x[OUT_WIDTH-1:0];
`else
        return x[OUT_WIDTH-1:0];
`endif
    endfunction

    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [CW-1:0]        wr_col_q, wr_col_d;
    logic [CW-1:0]        rd_row_q, rd_row_d;
    logic [PIX_WIDTH-1:0] mem_q [2][N][N];
    logic [PIX_WIDTH-1:0] col_w [N];
    logic                 accept;
    logic                 handshake;
    logic                 valid_w;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign col_w[gi] = bus.column_i[gi*PIX_WIDTH +: PIX_WIDTH];
    end

    // ready_o depends on flops only, so upstream never sees a path from ready_i.
    assign bus.ready_o = ~full_q[wr_bank_q];
    assign accept      = bus.en_i & bus.valid_i & ~full_q[wr_bank_q];
    assign valid_w     = full_q[rd_bank_q];
    assign handshake   = valid_w & bus.ready_i;
    assign bus.valid_o = valid_w;
    assign bus.last_o  = valid_w & (rd_row_q == LAST_IDX);

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_col_d  = wr_col_q;
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        // A bank cannot be filled and drained on the same edge: accept needs it empty,
        // a handshake needs it full. So both updates to full_d are independent.
        if (accept) begin
            if (wr_col_q == LAST_IDX) begin
                wr_col_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
        end
        if (handshake) begin
            if (rd_row_q == LAST_IDX) begin
                rd_row_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_row_d = rd_row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_col_q  <= '0;
            rd_row_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_col_q  <= wr_col_d;
            rd_row_q  <= rd_row_d;
        end
    end

    // Tile storage needs no reset: the full flags hide anything stale.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_bank_q][wr_col_q] <= col_w;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign bus.row_o[gi*OUT_WIDTH +: OUT_WIDTH] =
            valid_w ? narrow(mem_q[rd_bank_q][gi][rd_row_q]) : '0;
    end
endmodule

// File: tb/tb_overlap_tile_transposer.sv
// Scoreboard bench for overlap_tile_transposer: transpose, ping-pong, stall,
// backpressure, mid-tile reset and pixel narrowing.
module tb_overlap_tile_transposer;
    localparam int N   = 6;
    localparam int PW  = 8;
    localparam int OW  = 8;
    localparam int OWN = 6;
    localparam int RW  = OW * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    overlap_tile_transposer_if #(.N(N), .PIX_WIDTH(PW), .OUT_WIDTH(OW))  bus   ();
    overlap_tile_transposer_if #(.N(N), .PIX_WIDTH(PW), .OUT_WIDTH(OWN)) bus_n ();

    overlap_tile_transposer #(.N(N), .PIX_WIDTH(PW), .OUT_WIDTH(OW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    overlap_tile_transposer #(.N(N), .PIX_WIDTH(PW), .OUT_WIDTH(OWN)) dut_n (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_n)
    );

    typedef struct packed {
        logic [RW-1:0] row;
        logic          last;
    } exp_t;

    exp_t          sb_q[$];
    logic [RW-1:0] seen_q[$];
    int            errors = 0;
    int            checks = 0;

    function automatic logic [PW-1:0] pix(input int t, input int c, input int r);
        logic [31:0] v;
        v = 32'(16 * c + r + 37 * t);
        return v[PW-1:0];
    endfunction

    function automatic logic [PW*N-1:0] make_col(input int t, input int c);
        logic [PW*N-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++) v[r*PW +: PW] = pix(t, c, r);
        return v;
    endfunction

    task automatic expect_tile(input int t);
        exp_t e;
        for (int r = 0; r < N; r++) begin
            e.row = '0;
            for (int c = 0; c < N; c++) e.row[c*OW +: OW] = pix(t, c, r);
            e.last = (r == N - 1);
            sb_q.push_back(e);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_col(input int t, input int c, output int waited);
        int w;
        w = 0;
        bus.column_i = make_col(t, c);
        bus.valid_i  = 1'b1;
        @(negedge clk);
        while (!bus.ready_o) begin
            w++;
            if (w > 400) begin
                checks++; errors++;
                $display("FAIL send_timeout: ready_o=%b required 1 (tile %0d col %0d)", bus.ready_o, t, c);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        $display("col  t=%0t tile=%0d col=%0d waited=%0d", $time, t, c, w);
        waited = w;
    endtask

    task automatic drain_rows(input int n, input int budget, output int gaps);
        int   got;
        int   cyc;
        bit   started;
        exp_t e;
        got = 0; cyc = 0; started = 0; gaps = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.valid_o && bus.ready_i) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL row_unexpected: row_o=%h last_o=%b required no row", bus.row_o, bus.last_o);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.row_o !== e.row || bus.last_o !== e.last) begin
                        errors++;
                        $display("FAIL row_data: row_o=%h last_o=%b required row %h last %b",
                                 bus.row_o, bus.last_o, e.row, e.last);
                    end
                end
                seen_q.push_back(bus.row_o);
                $display("row  t=%0t row=%h last=%b", $time, bus.row_o, bus.last_o);
                got++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
        end
        if (got < n) begin
            checks++; errors++;
            $display("FAIL drain_timeout: rows=%0d required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: ready_o=%b required 1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: valid_o=%b required 0", bus.valid_o); end
        checks++; if (bus.last_o !== 1'b0) begin errors++; $display("FAIL reset_last: last_o=%b required 0", bus.last_o); end
        checks++; if (bus.row_o !== '0) begin errors++; $display("FAIL reset_row: row_o=%h required 0", bus.row_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_transpose();
        int            w;
        int            gaps;
        logic [RW-1:0] row2_exp;
        row2_exp    = 48'h524232221202;
        bus.ready_i = 1'b1;
        seen_q.delete();
        expect_tile(0);
        for (int c = 0; c < N; c++) begin
            send_col(0, c, w);
            if (c == N - 2) begin
                checks++;
                if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL early_valid: valid_o=%b required 0", bus.valid_o); end
            end
        end
        checks++;
        if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL valid_latency: valid_o=%b required 1", bus.valid_o); end
        drain_rows(N, 20, gaps);
        checks++;
        if (seen_q.size() < 3 || seen_q[2] !== row2_exp) begin
            errors++;
            $display("FAIL transpose_row2: row=%h required %h", (seen_q.size() > 2) ? seen_q[2] : '0, row2_exp);
        end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL transpose_gaps: gaps=%0d required 0", gaps); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL transpose_end: valid_o=%b required 0", bus.valid_o); end
    endtask

    task automatic test_ping_pong();
        int totw;
        int w;
        int gaps;
        totw = 0;
        bus.ready_i = 1'b1;
        expect_tile(1);
        expect_tile(2);
        fork
            begin
                for (int t = 1; t <= 2; t++)
                    for (int c = 0; c < N; c++) begin
                        send_col(t, c, w);
                        totw += w;
                    end
            end
            drain_rows(2 * N, 80, gaps);
        join
        checks++;
        if (totw != 0) begin errors++; $display("FAIL pingpong_ready: stall_cycles=%0d required 0", totw); end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL pingpong_gaps: gaps=%0d required 0", gaps); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_stall();
        int w;
        int gaps;
        bus.ready_i = 1'b0;
        expect_tile(3);
        expect_tile(4);
        expect_tile(5);
        for (int t = 3; t <= 4; t++)
            for (int c = 0; c < N; c++) send_col(t, c, w);
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready: ready_o=%b required 0", bus.ready_o); end
        bus.column_i = make_col(5, 0);
        bus.valid_i  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL stall_hold: ready_o=%b required 0", bus.ready_o); end
        @(posedge clk);
        #1 bus.ready_i = 1'b1;
        drain_rows(N, 20, gaps);
        checks++;
        if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL stall_early_ready: ready_o=%b required 0", bus.ready_o); end
        @(posedge clk);
        #1 bus.ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL stall_release: ready_o=%b required 1", bus.ready_o); end
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        $display("col  t=%0t tile=5 col=0 (held column)", $time);
        bus.ready_i = 1'b1;
        fork
            for (int c = 1; c < N; c++) send_col(5, c, w);
            drain_rows(2 * N, 80, gaps);
        join
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int            w;
        int            i;
        int            got;
        bit            have_held;
        logic [RW-1:0] held_row;
        logic          held_last;
        bit            pat[4];
        exp_t          e;
        int            gaps;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus.ready_i = 1'b0;
        expect_tile(6);
        for (int c = 0; c < N; c++) send_col(6, c, w);
        bus.en_i     = 1'b0;
        bus.valid_i  = 1'b1;
        bus.column_i = make_col(99, 0);
        i = 0; got = 0; have_held = 0; held_row = '0; held_last = 1'b0;
        while (got < N && i < 60) begin
            bus.ready_i = pat[i % 4];
            @(negedge clk);
            if (bus.valid_o) begin
                if (have_held) begin
                    checks++;
                    if (bus.row_o !== held_row || bus.last_o !== held_last) begin
                        errors++;
                        $display("FAIL bp_stable: row_o=%h last_o=%b required %h %b", bus.row_o, bus.last_o, held_row, held_last);
                    end
                end
                if (bus.ready_i) begin
                    checks++;
                    e = sb_q.pop_front();
                    if (bus.row_o !== e.row || bus.last_o !== e.last) begin
                        errors++;
                        $display("FAIL bp_row: row_o=%h last_o=%b required %h %b", bus.row_o, bus.last_o, e.row, e.last);
                    end
                    $display("row  t=%0t row=%h last=%b", $time, bus.row_o, bus.last_o);
                    have_held = 0;
                    got++;
                end else begin
                    held_row  = bus.row_o;
                    held_last = bus.last_o;
                    have_held = 1;
                    checks++;
                    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_en_ready: ready_o=%b required 1", bus.ready_o); end
                end
            end
            @(posedge clk);
            #1;
            i++;
        end
        if (got < N) begin checks++; errors++; $display("FAIL bp_timeout: rows=%0d required %0d", got, N); end
        bus.valid_i = 1'b0;
        bus.en_i    = 1'b1;
        bus.ready_i = 1'b1;
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_en_accepted: valid_o=%b required 0", bus.valid_o); end
        expect_tile(7);
        fork
            for (int c = 0; c < N; c++) send_col(7, c, w);
            drain_rows(N, 40, gaps);
        join
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        int w;
        int gaps;
        bus.ready_i = 1'b0;
        for (int c = 0; c < N; c++) send_col(8, c, w);
        for (int c = 0; c < 3; c++) send_col(9, c, w);
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL prereset_valid: valid_o=%b required 1", bus.valid_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: valid_o=%b required 0", bus.valid_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready: ready_o=%b required 1", bus.ready_o); end
        checks++; if (bus.row_o !== '0) begin errors++; $display("FAIL midreset_row: row_o=%h required 0", bus.row_o); end
        #1 rst_n = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 bus.ready_i = 1'b1;
        expect_tile(10);
        fork
            for (int c = 0; c < N; c++) send_col(10, c, w);
            drain_rows(N, 40, gaps);
        join
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL postreset_end: valid_o=%b required 0", bus.valid_o); end
    endtask

    task automatic test_narrowing();
        logic [PW*N-1:0]  col;
        logic [OWN-1:0]   exp50;
        logic [OWN*N-1:0] e0;
        logic [OWN*N-1:0] e1;
        logic [OWN*N-1:0] e2;
`ifdef OVERLAP_TILE_SATURATE_EN
        exp50 = 6'h3F;
`else
        exp50 = 6'h10;
`endif
        e0  = {N{exp50}};
        e1  = {N{6'h2A}};
        e2  = {N{6'h05}};
        col = {N{8'h05}};
        col[0 +: PW]  = 8'h50;
        col[PW +: PW] = 8'h2A;
        bus_n.ready_i = 1'b1;
        for (int c = 0; c < N; c++) begin
            bus_n.column_i = col;
            bus_n.valid_i  = 1'b1;
            @(negedge clk);
            checks++;
            if (bus_n.ready_o !== 1'b1) begin errors++; $display("FAIL narrow_ready: ready_o=%b required 1", bus_n.ready_o); end
            @(posedge clk);
            #1;
        end
        bus_n.valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_n.valid_o !== 1'b1 || bus_n.row_o !== e0) begin
            errors++; $display("FAIL narrow_0x50: valid_o=%b row_o=%h required 1 %h", bus_n.valid_o, bus_n.row_o, e0);
        end
        $display("row  t=%0t narrow row=%h", $time, bus_n.row_o);
        @(negedge clk);
        checks++;
        if (bus_n.row_o !== e1) begin errors++; $display("FAIL narrow_0x2a: row_o=%h required %h", bus_n.row_o, e1); end
        $display("row  t=%0t narrow row=%h", $time, bus_n.row_o);
        @(negedge clk);
        checks++;
        if (bus_n.row_o !== e2) begin errors++; $display("FAIL narrow_0x05: row_o=%h required %h", bus_n.row_o, e2); end
        $display("row  t=%0t narrow row=%h", $time, bus_n.row_o);
        repeat (N) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bus.en_i       = 1'b1;
        bus.valid_i    = 1'b0;
        bus.column_i   = '0;
        bus.ready_i    = 1'b1;
        bus_n.en_i     = 1'b1;
        bus_n.valid_i  = 1'b0;
        bus_n.column_i = '0;
        bus_n.ready_i  = 1'b1;
        test_reset();
        test_transpose();
        test_ping_pong();
        test_full_stall();
        test_backpressure();
        test_mid_reset();
        test_narrowing();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: entries=%0d required 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
